sd_sector_reader: RTL and testbench

Read-side sequencer that sits directly downstream of the SD card SPI controller. It accepts a one-cycle start request with a sector number and drives the controller's `rd`/`address` handshake. It captures the 512 bytes the controller presents on `dout`/`byte_available` into an internal 512×8 buffer, then reports completion with a byte count and a 16-bit additive checksum. The buffer is exposed to the consumer (display/UART logic) through a synchronous read port.

---
 rtl/sd_sector_reader.sv | 216 +++++++++++++++++++++
 tb/tb_sd_sector_reader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sd_sector_reader.sv
// ---------------------------------------------------------------------------
// sd_sector_reader
// Read-side sequencer for the SD card SPI controller. A one-cycle start
// request latches a sector number and runs the controller's rd/address
// handshake. The 512 data bytes the controller presents are captured into an
// internal 512x8 buffer. Completion is reported with a byte count and a 16-bit
// additive checksum. A watchdog aborts a stalled transfer.
//
// Ports
//   clk_i, reset_i            clock, synchronous active-high reset
//   start_i, sector_i         request pulse (IDLE only) and sector number
//   busy_o, done_o, error_o   transfer status (done is a 1-cycle pulse,
//                             error is sticky until the next accepted start)
//   byte_count_o, checksum_o  bytes stored so far (0..512), byte sum mod 2^16
//   buf_addr_i, buf_data_o    consumer read port, 1-cycle registered latency
//   sd_ready_i, sd_rd_o       controller ready / read request
//   sd_address_o              controller address (block or byte addressing)
//   sd_dout_i,
//   sd_byte_available_i       controller data byte and its strobe
// ---------------------------------------------------------------------------
module sd_sector_reader #(
  parameter bit          BYTE_ADDR      = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 25_000_000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [31:0] sector_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [9:0]  byte_count_o,
  output logic [15:0] checksum_o,
  input  logic [8:0]  buf_addr_i,
  output logic [7:0]  buf_data_o,
  input  logic        sd_ready_i,
  output logic        sd_rd_o,
  output logic [31:0] sd_address_o,
  input  logic [7:0]  sd_dout_i,
  input  logic        sd_byte_available_i
);

  // The watchdog only ever needs to hold values up to TIMEOUT_CYCLES-1.
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_READY = 3'd1,
    S_ISSUE      = 3'd2,
    S_COLLECT    = 3'd3,
    S_DONE       = 3'd4,
    S_ERROR      = 3'd5
  } state_t;

  state_t        state_q;
  logic          busy_q;
  logic          done_q;
  logic          error_q;
  logic          sd_rd_q;
  logic [31:0]   sd_address_q;
  logic [9:0]    byte_count_q;
  logic [15:0]   checksum_q;
  logic [TW-1:0] tmo_q;
  logic          avail_q;
  logic [7:0]    buf_data_q;
  logic [7:0]    mem_q [512];

  logic          byte_evt;
  logic          tmo_hit;
  logic          buf_we;
  logic [9:0]    byte_count_d;
  logic [15:0]   checksum_d;
  logic [31:0]   sd_address_d;
  logic [TW-1:0] tmo_d;

  // A level held high on byte_available counts as a single byte.
  assign byte_evt     = sd_byte_available_i & ~avail_q;
  assign tmo_hit      = (tmo_q == TMO_LAST);
  assign buf_we       = (state_q == S_COLLECT) & byte_evt;
  assign byte_count_d = byte_count_q + 10'd1;
  assign checksum_d   = checksum_q + {8'h00, sd_dout_i};
  assign tmo_d        = tmo_q + TW'(1);
  // SDSC cards take a byte address; the shift drops the upper sector bits.
  assign sd_address_d = BYTE_ADDR ? (sector_i << 9) : sector_i;

  // Transfer sequencer: state, handshake outputs, counters and watchdog.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      sd_rd_q      <= 1'b0;
      sd_address_q <= 32'h0000_0000;
      byte_count_q <= 10'd0;
      checksum_q   <= 16'h0000;
      tmo_q        <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            sd_address_q <= sd_address_d;
            byte_count_q <= 10'd0;
            checksum_q   <= 16'h0000;
            error_q      <= 1'b0;
            tmo_q        <= '0;
            busy_q       <= 1'b1;
            state_q      <= S_WAIT_READY;
          end
        end
        S_WAIT_READY: begin
          if (sd_ready_i) begin
            sd_rd_q <= 1'b1;
            tmo_q   <= '0;
            state_q <= S_ISSUE;
          end else if (tmo_hit) begin
            sd_rd_q <= 1'b0;
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            tmo_q   <= '0;
            state_q <= S_ERROR;
          end else begin
            tmo_q <= tmo_d;
          end
        end
        S_ISSUE: begin
          // rd is level-sensitive in the controller, so release it as soon
          // as the controller has left ready.
          if (!sd_ready_i) begin
            sd_rd_q <= 1'b0;
            tmo_q   <= '0;
            state_q <= S_COLLECT;
          end else if (tmo_hit) begin
            sd_rd_q <= 1'b0;
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            tmo_q   <= '0;
            state_q <= S_ERROR;
          end else begin
            tmo_q <= tmo_d;
          end
        end
        S_COLLECT: begin
          if (byte_evt) begin
            byte_count_q <= byte_count_d;
            checksum_q   <= checksum_d;
            tmo_q        <= '0;
            if (byte_count_q == 10'd511) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end else if (tmo_hit) begin
            sd_rd_q <= 1'b0;
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            tmo_q   <= '0;
            state_q <= S_ERROR;
          end else begin
            tmo_q <= tmo_d;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        S_ERROR: begin
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          sd_rd_q <= 1'b0;
          tmo_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Registered copy of byte_available for rising-edge detection.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      avail_q <= 1'b0;
    end else begin
      avail_q <= sd_byte_available_i;
    end
  end

  // Buffer write port; contents survive reset and new requests.
  always_ff @(posedge clk_i) begin
    if (buf_we) begin
      mem_q[byte_count_q[8:0]] <= sd_dout_i;
    end
  end

  // Buffer read port; a same-cycle write to the same address returns old data.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      buf_data_q <= 8'h00;
    end else begin
      buf_data_q <= mem_q[buf_addr_i];
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign error_o      = error_q;
  assign sd_rd_o      = sd_rd_q;
  assign sd_address_o = sd_address_q;
  assign byte_count_o = byte_count_q;
  assign checksum_o   = checksum_q;
  assign buf_data_o   = buf_data_q;

endmodule

// File: tb/tb_sd_sector_reader.sv
// ---------------------------------------------------------------------------
// tb_sd_sector_reader
// Directed bench for sd_sector_reader. Two instances: dut0 uses block
// addressing with a 1000-cycle watchdog, dut1 uses byte addressing with a
// 50-cycle watchdog. A small controller model per instance drives the
// ready/rd handshake and a byte stream whose value equals the byte index.
// ---------------------------------------------------------------------------
module tb_sd_sector_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset [2];
  logic        start [2];
  logic        ready [2];
  logic        avail [2];
  logic [31:0] sector[2];
  logic [7:0]  dout  [2];
  logic [8:0]  baddr [2];
  logic        busy  [2];
  logic        done  [2];
  logic        error [2];
  logic        sd_rd [2];
  logic [9:0]  bcnt  [2];
  logic [15:0] csum  [2];
  logic [7:0]  bdata [2];
  logic [31:0] saddr [2];

  int n_vec = 0;
  int n_bad = 0;
  int done_seen[2];

  sd_sector_reader #(.BYTE_ADDR(1'b0), .TIMEOUT_CYCLES(1000)) dut0 (
    .clk_i(clk), .reset_i(reset[0]), .start_i(start[0]), .sector_i(sector[0]),
    .busy_o(busy[0]), .done_o(done[0]), .error_o(error[0]),
    .byte_count_o(bcnt[0]), .checksum_o(csum[0]),
    .buf_addr_i(baddr[0]), .buf_data_o(bdata[0]),
    .sd_ready_i(ready[0]), .sd_rd_o(sd_rd[0]), .sd_address_o(saddr[0]),
    .sd_dout_i(dout[0]), .sd_byte_available_i(avail[0])
  );

  sd_sector_reader #(.BYTE_ADDR(1'b1), .TIMEOUT_CYCLES(50)) dut1 (
    .clk_i(clk), .reset_i(reset[1]), .start_i(start[1]), .sector_i(sector[1]),
    .busy_o(busy[1]), .done_o(done[1]), .error_o(error[1]),
    .byte_count_o(bcnt[1]), .checksum_o(csum[1]),
    .buf_addr_i(baddr[1]), .buf_data_o(bdata[1]),
    .sd_ready_i(ready[1]), .sd_rd_o(sd_rd[1]), .sd_address_o(saddr[1]),
    .sd_dout_i(dout[1]), .sd_byte_available_i(avail[1])
  );

  // Count done pulses per instance.
  always @(posedge clk) begin
    for (int j = 0; j < 2; j++) begin
      if (done[j]) done_seen[j] <= done_seen[j] + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_rd(input int d, input logic v);
    int n = 0;
    while (sd_rd[d] !== v && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("wait_rd", 32'(sd_rd[d]), 32'(v));
  endtask

  task automatic rst_check(input int d);
    check_eq("rst_busy",  32'(busy[d]),  32'd0);
    check_eq("rst_done",  32'(done[d]),  32'd0);
    check_eq("rst_error", 32'(error[d]), 32'd0);
    check_eq("rst_sd_rd", 32'(sd_rd[d]), 32'd0);
    check_eq("rst_count", 32'(bcnt[d]),  32'd0);
    check_eq("rst_csum",  32'(csum[d]),  32'd0);
    check_eq("rst_addr",  saddr[d],      32'd0);
    check_eq("rst_bdata", 32'(bdata[d]), 32'd0);
  endtask

  // Controller model: start, handshake, then nbytes with value = index.
  task automatic xfer(input int d, input logic [31:0] sec, input int nbytes,
                      input int hold, input int gap, input int crc,
                      input int rdy_delay, input int poke);
    if (rdy_delay > 0) ready[d] = 1'b0;
    @(negedge clk);
    start[d]  = 1'b1;
    sector[d] = sec;
    @(negedge clk);
    start[d]  = 1'b0;
    check_eq("busy_on_accept", 32'(busy[d]), 32'd1);
    for (int c = 0; c < rdy_delay; c++) begin
      check_eq("rd_wait_low", 32'(sd_rd[d]), 32'd0);
      @(negedge clk);
    end
    ready[d] = 1'b1;
    wait_rd(d, 1'b1);
    ready[d] = 1'b0;
    @(negedge clk);
    check_eq("rd_drop", 32'(sd_rd[d]), 32'd0);
    for (int i = 0; i < nbytes; i++) begin
      dout[d]  = 8'(i);
      avail[d] = 1'b1;
      if (i == poke) start[d] = 1'b1;
      @(negedge clk);
      start[d] = 1'b0;
      repeat (hold - 1) @(negedge clk);
      avail[d] = 1'b0;
      repeat (gap - hold) @(negedge clk);
    end
    for (int c = 0; c < crc; c++) begin
      dout[d]  = 8'hAB;
      avail[d] = 1'b1;
      repeat (3) @(negedge clk);
      avail[d] = 1'b0;
      repeat (3) @(negedge clk);
    end
    ready[d] = 1'b1;
  endtask

  task automatic end_check(input int d, input int done_before, input logic [9:0] cnt,
                           input logic [15:0] sum, input logic [31:0] addr,
                           input logic err, input int exp_done);
    int n = 0;
    while (busy[d] !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("busy_drop", 32'(busy[d]),  32'd0);
    check_eq("done_count", 32'(done_seen[d] - done_before), 32'(exp_done));
    check_eq("byte_count", 32'(bcnt[d]),  32'(cnt));
    check_eq("checksum",   32'(csum[d]),  32'(sum));
    check_eq("sd_address", saddr[d],      addr);
    check_eq("error",      32'(error[d]), 32'(err));
  endtask

  task automatic rd_buf(input int d, input logic [8:0] a, input logic [7:0] exp);
    @(negedge clk);
    baddr[d] = a;
    @(negedge clk);
    check_eq("buf_data", 32'(bdata[d]), 32'(exp));
  endtask

  initial begin
    int ds;
    int k;
    for (int j = 0; j < 2; j++) begin
      reset[j]  = 1'b1;
      start[j]  = 1'b0;
      ready[j]  = 1'b1;
      avail[j]  = 1'b0;
      sector[j] = 32'd0;
      dout[j]   = 8'h00;
      baddr[j]  = 9'd0;
    end
    repeat (3) @(negedge clk);
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    rst_check(0);
    rst_check(1);

    // Block addressing, two passes of 0x00..0xFF, 16-clock byte spacing.
    ds = done_seen[0];
    xfer(0, 32'h12, 512, 1, 16, 0, 0, -1);
    end_check(0, ds, 10'd512, 16'hFF00, 32'h12, 1'b0, 1);
    rd_buf(0, 9'h1FF, 8'hFF);
    rd_buf(0, 9'h000, 8'h00);
    rd_buf(0, 9'h100, 8'h00);
    rd_buf(0, 9'h13A, 8'h3A);

    // Byte addressing: sector 3 -> address 0x600.
    ds = done_seen[1];
    xfer(1, 32'd3, 512, 1, 16, 0, 0, -1);
    end_check(1, ds, 10'd512, 16'hFF00, 32'h600, 1'b0, 1);
    rd_buf(1, 9'h0FF, 8'hFF);

    // Controller not ready for 100 cycles after start.
    ds = done_seen[0];
    xfer(0, 32'h40, 512, 1, 4, 0, 100, -1);
    end_check(0, ds, 10'd512, 16'hFF00, 32'h40, 1'b0, 1);

    // Strobe held 3 cycles per byte, then two CRC pulses that must be ignored.
    ds = done_seen[0];
    xfer(0, 32'h55, 512, 3, 8, 2, 0, -1);
    end_check(0, ds, 10'd512, 16'hFF00, 32'h55, 1'b0, 1);
    rd_buf(0, 9'h0FF, 8'hFF);

    // Stall after 10 bytes with a 50-cycle watchdog.
    ds = done_seen[1];
    xfer(1, 32'd5, 10, 1, 16, 0, 0, -1);
    k = 16;
    while (k < 80 && error[1] !== 1'b1) begin
      @(negedge clk);
      k++;
    end
    check_eq("tmo_latency", 32'(k), 32'd51);
    end_check(1, ds, 10'd10, 16'h002D, 32'hA00, 1'b1, 0);
    check_eq("tmo_sd_rd", 32'(sd_rd[1]), 32'd0);
    @(negedge clk);
    start[1]  = 1'b1;
    sector[1] = 32'd7;
    @(negedge clk);
    start[1]  = 1'b0;
    check_eq("restart_error", 32'(error[1]), 32'd0);
    check_eq("restart_busy",  32'(busy[1]),  32'd1);
    check_eq("restart_addr",  saddr[1],      32'hE00);
    // Ready never falls, so the request stalls in the handshake and aborts.
    end_check(1, ds, 10'd0, 16'h0000, 32'hE00, 1'b1, 0);
    check_eq("issue_tmo_rd", 32'(sd_rd[1]), 32'd0);

    // Reset at byte 200, then a clean transfer with a stray start in COLLECT.
    ds = done_seen[0];
    xfer(0, 32'h12, 200, 1, 4, 0, 0, -1);
    check_eq("mid_busy",  32'(busy[0]), 32'd1);
    check_eq("mid_count", 32'(bcnt[0]), 32'd200);
    check_eq("mid_csum",  32'(csum[0]), 32'h4DBC);
    @(negedge clk);
    reset[0] = 1'b1;
    @(negedge clk);
    reset[0] = 1'b0;
    rst_check(0);
    xfer(0, 32'h12, 512, 1, 4, 0, 0, 100);
    end_check(0, ds, 10'd512, 16'hFF00, 32'h12, 1'b0, 1);
    rd_buf(0, 9'h1C8, 8'hC8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
